// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for RegFile and its write-back initiators.
//   RF_ADDR_W  : register index width
//   RF_DATA_W  : register data width
//   wb_entry_t : one pending register write {wreg, data}
package regfile_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] wreg;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match
// Priority match over the write-back queue storage. Entries are visited
// oldest to youngest, starting at the read pointer, so the last match
// found is the youngest write to the lookup index.
//   ent_reg/ent_data : queue storage arrays (indexed by physical slot)
//   rd_ptr           : slot of the oldest valid entry
//   occupancy        : number of valid entries
//   lookup           : register index to search for
//   hit/data         : youngest match, or 0/0 on a miss
module wb_fwd_match
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic [ADDR_W-1:0]        ent_reg  [DEPTH],
  input  logic [DATA_W-1:0]        ent_data [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  input  logic [$clog2(DEPTH):0]   occupancy,
  input  logic [ADDR_W-1:0]        lookup,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      // pointer arithmetic wraps naturally at DEPTH (power of two)
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < occupancy) && (ent_reg[idx] == lookup)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue
// Buffered write-back initiator for RegFile. Register results are accepted
// over a valid/ready handshake into a DEPTH-entry circular buffer and
// committed in order, at most one per cycle, on the RegFile write port.
// Two combinational lookups expose queued, not-yet-committed writes.
//   clock, reset_n          : clock, async active-low reset
//   in_valid/in_ready       : enqueue handshake (in_ready = !full)
//   in_reg/in_data          : write to enqueue
//   wb_stall                : holds the head, suppresses the commit
//   RegWrite/WriteReg/WriteData : RegFile write port (zeros when empty)
//   fwd_reg1/2, fwd_hit1/2, fwd_data1/2 : forwarding lookups
//   count/empty/full        : occupancy status (from registers only)
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_reg,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   wb_stall,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      WriteReg,
  output logic [DATA_W-1:0]      WriteData,
  input  logic [ADDR_W-1:0]      fwd_reg1,
  input  logic [ADDR_W-1:0]      fwd_reg2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DATA_W-1:0]      fwd_data1,
  output logic [DATA_W-1:0]      fwd_data2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  // ready looks only at the registered count, never at wb_stall or a pop
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign RegWrite = !empty && !wb_stall;
  assign pop      = RegWrite;

  assign WriteReg  = empty ? '0 : ent_reg[rd_ptr];
  assign WriteData = empty ? '0 : ent_data[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left uncleared by reset; validity comes from count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      ent_reg[wr_ptr]  <= in_reg;
      ent_data[wr_ptr] <= in_data;
    end
  end

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fwd1 (
    .ent_reg  (ent_reg),
    .ent_data (ent_data),
    .rd_ptr   (rd_ptr),
    .occupancy(count),
    .lookup   (fwd_reg1),
    .hit      (fwd_hit1),
    .data     (fwd_data1)
  );

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fwd2 (
    .ent_reg  (ent_reg),
    .ent_data (ent_data),
    .rd_ptr   (rd_ptr),
    .occupancy(count),
    .lookup   (fwd_reg2),
    .hit      (fwd_hit2),
    .data     (fwd_data2)
  );

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffered write-back initiator for `RegFile`. Accepts register results from the execute/memory side over a valid/ready handshake and holds them in a DEPTH-entry FIFO. Issues at most one write per cycle on the `RegFile` write port (`RegWrite`/`WriteReg`/`WriteData`). Provides two forwarding lookups so read operands see queued but not-yet-committed writes.

## Interface

Parameters:
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `ADDR_W`, default 5: register index width.
- `DATA_W`, default 32: register data width.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a write to enqueue.
- `in_ready`  out  1  queue can accept this cycle.
- `in_reg`  in  ADDR_W  destination register index.
- `in_data`  in  DATA_W  destination data.
- `wb_stall`  in  1  inhibits the commit this cycle.
- `RegWrite`  out  1  write strobe to `RegFile`.
- `WriteReg`  out  ADDR_W  write index to `RegFile`.
- `WriteData`  out  DATA_W  write data to `RegFile`.
- `fwd_reg1`, `fwd_reg2`  in  ADDR_W  lookup indices; connect alongside `ReadReg1`/`ReadReg2`.
- `fwd_hit1`, `fwd_hit2`  out  1  a queued entry targets the lookup index.
- `fwd_data1`, `fwd_data2`  out  DATA_W  data of the youngest matching entry.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `empty`, `full`  out  1  occupancy is 0 / occupancy is DEPTH.

## Operation

- Storage: circular buffer of {reg, data} with read pointer, write pointer and count. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Push: occurs when `in_valid && in_ready`. `in_ready = !full`; it does not depend combinationally on `wb_stall` or on a pop in the same cycle.
- Commit:
  - `RegWrite = !empty && !wb_stall`.
  - `WriteReg`/`WriteData` show the head entry when `!empty`, and all zeros when empty.
  - Pop occurs when `RegWrite` is 1.
- Simultaneous push and pop:
  - The count is unchanged.
  - When the queue is full, no push occurs, because `in_ready` is 0.
- Forwarding lookup (combinational):
  - Each lookup scans all valid entries, including the head entry being committed this cycle.
  - A hit returns the youngest match.
  - The input port is not scanned.
  - On a miss, hit is 0 and data is 0.
- Register 0 is an ordinary writable register. It gets no discard and no special case.
- Ordering: commits leave strictly in acceptance order. There is no write coalescing.
- Reset, asynchronous while `reset_n` is 0:
  - Pointers and count go to 0; `empty`=1, `full`=0, `in_ready`=1.
  - `RegWrite`=0, `WriteReg`=0, `WriteData`=0, all `fwd_hit`=0.
  - Queued entries are discarded, with no partial commit. Entry storage need not be cleared.

## Timing

- Latency: an entry accepted at edge N is the head, and drives `RegWrite` if unstalled, in cycle N→N+1. `RegFile` captures it at edge N+1. There is no same-cycle pass-through.
- Throughput: one accept and one commit per cycle sustained. A full queue accepts again the cycle after a pop.
- `count`, `empty` and `full` are registered, or derived only from registers. `in_ready` has no combinational path from any input.
- Forward outputs are combinational from state plus `fwd_reg*`. The hit window holds until the edge that commits the entry; after that edge, `RegFile` holds the value.
- `wb_stall` held high: the head is held stable, `RegWrite`=0, and pushes continue until full.

## Structure

- Shared package `regfile_pkg`: `ADDR_W`/`DATA_W` constants and a `wb_entry_t` struct {reg, data}. `RegFile` users share these.
- One natural sub-module: `wb_fwd_match`, a priority match over the entry array (age-ordered from the read pointer) that returns hit/data. It is instantiated twice.

## Test plan

- Reset, then push (r3, 0x0000_00AA) with `wb_stall`=0: the next cycle shows `RegWrite`=1, `WriteReg`=3, `WriteData`=0xAA; `RegFile` r3 = 0xAA one edge later; `empty` returns to 1.
- `wb_stall`=1, push 4 entries (r1..r4, values 1..4): `full`=1, `in_ready`=0, a 5th `in_valid` is ignored. Release the stall: 4 consecutive commits r1..r4 in order, and `in_ready`=1 in the cycle after the first commit.
- Stall, push (r5, 0x11) then (r5, 0x22), set `fwd_reg1`=5: `fwd_hit1`=1, `fwd_data1`=0x22. `fwd_reg2`=6 gives `fwd_hit2`=0 and `fwd_data2`=0.
- Continuous push and pop: 16 back-to-back writes with `wb_stall`=0. `count` stays at 1, there are 16 commits in order, and the pointers wrap with no loss.
- Push (r0, 0x55): it commits with `WriteReg`=0; `RegFile` r0 reads 0x55.
- With 3 entries queued, assert `reset_n`=0 mid-stream: `RegWrite` drops immediately, `count`=0 and `empty`=1. After release, no stale entry is ever committed.
